crc_frame_engine: RTL and testbench

CRC_FRAME_ENGINE -- requirements
Module: crc_frame_engine

---
 rtl/crc_frame_engine.sv | 143 ++++++++++++++
 tb/tb_crc_frame_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_engine.sv
// rtl/crc_frame_engine.sv - per-frame CRC insertion (map) or checking (demap) on a row/column byte stream
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_row_cnt, i_col_cnt           position of the current byte within the frame
//   i_frame_data[_valid|_fas]      input byte, qualifier, frame start (row 0, col 0)
//   o_frame_data[_valid|_fas]      input stream delayed one cycle; CRC bytes inserted in map mode
//   o_crc_val                      running CRC register
//   o_crc_err, o_crc_err_cnt       demap mismatch flag (held until next fas) and saturating frame count
//   o_frame_done                   one-cycle pulse with the output of the last CRC slot byte
module crc_frame_engine #(
    parameter int               MAP_MODE  = 1,
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = 'h07,
    parameter logic [CRC_W-1:0] CRC_INIT  = '0,
    parameter int               ROW_W     = 2,
    parameter int               COL_W     = 11,
    parameter int               PAY_FIRST = 16,
    parameter int               PAY_LAST  = 1039,
    parameter int               CRC_ROW   = 3,
    parameter int               ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ROW_W-1:0]     i_row_cnt,
    input  logic [COL_W-1:0]     i_col_cnt,
    input  logic [7:0]           i_frame_data,
    input  logic                 i_frame_data_valid,
    input  logic                 i_frame_data_fas,
    output logic [7:0]           o_frame_data,
    output logic                 o_frame_data_valid,
    output logic                 o_frame_data_fas,
    output logic [CRC_W-1:0]     o_crc_val,
    output logic                 o_crc_err,
    output logic [ERR_CNT_W-1:0] o_crc_err_cnt,
    output logic                 o_frame_done
);

    localparam int NB = CRC_W / 8;

    typedef enum logic [1:0] {WAIT_FAS, ACCUM, CRC_SLOT} state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [1:0]       k_q, k_d, idx;
    logic             sticky_q, sticky_d, sticky_acc;
    logic [7:0]       data_d, crc_byte;
    logic             done_d, err_d, cnt_inc;
    logic             in_payload, slot_start, slot_byte, mismatch;

    // Bit-serial MSB-first division, unrolled over the 8 data bits.
    function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c, input logic [7:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0};
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= WAIT_FAS;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        k_d      = k_q;
        sticky_d = sticky_q;
        data_d   = i_frame_data;
        done_d   = 1'b0;
        err_d    = o_crc_err;
        cnt_inc  = 1'b0;

        in_payload = (i_col_cnt >= COL_W'(PAY_FIRST)) && (i_col_cnt <= COL_W'(PAY_LAST));
        slot_start = (state_q == ACCUM) && (i_row_cnt == ROW_W'(CRC_ROW))
                     && (i_col_cnt == COL_W'(PAY_LAST + 1));
        // The byte that triggers the slot entry is itself slot byte 0.
        slot_byte  = i_frame_data_valid && (slot_start || (state_q == CRC_SLOT));
        idx        = (state_q == CRC_SLOT) ? k_q : 2'd0;
        crc_byte   = 8'(crc_q >> (CRC_W - 8 - 8 * int'(idx)));
        mismatch   = (i_frame_data != crc_byte);
        sticky_acc = ((state_q == CRC_SLOT) ? sticky_q : 1'b0) | mismatch;

        if (i_frame_data_valid && i_frame_data_fas) begin
            // A fas also aborts any frame in progress without flagging it.
            state_d  = ACCUM;
            crc_d    = CRC_INIT;
            k_d      = 2'd0;
            sticky_d = 1'b0;
            err_d    = 1'b0;
        end else if (slot_byte) begin
            if (MAP_MODE != 0) data_d   = crc_byte;
            else               sticky_d = sticky_acc;
            if (idx == 2'(NB - 1)) begin
                state_d = WAIT_FAS;
                k_d     = 2'd0;
                done_d  = 1'b1;
                if (MAP_MODE == 0) begin
                    err_d   = sticky_acc;
                    cnt_inc = sticky_acc;
                end
            end else begin
                state_d = CRC_SLOT;
                k_d     = idx + 2'd1;
            end
        end else if (i_frame_data_valid && (state_q == ACCUM) && in_payload) begin
            crc_d = crc_next(crc_q, i_frame_data);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            crc_q              <= CRC_INIT;
            k_q                <= 2'd0;
            sticky_q           <= 1'b0;
            o_frame_data       <= 8'h00;
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_frame_done       <= 1'b0;
            o_crc_err          <= 1'b0;
            o_crc_err_cnt      <= '0;
        end else begin
            crc_q              <= crc_d;
            k_q                <= k_d;
            sticky_q           <= sticky_d;
            o_frame_data       <= data_d;
            o_frame_data_valid <= i_frame_data_valid;
            o_frame_data_fas   <= i_frame_data_fas;
            o_frame_done       <= done_d;
            o_crc_err          <= err_d;
            if (cnt_inc && (o_crc_err_cnt != '1))
                o_crc_err_cnt <= o_crc_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign o_crc_val = crc_q;

endmodule

// File: tb/tb_crc_frame_engine.sv
// tb/tb_crc_frame_engine.sv - self-checking bench for crc_frame_engine (map8, map16, demap8, demap8 with 2-bit counter)
module tb_crc_frame_engine;

    localparam int NPAY = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  row = '0;
    logic [10:0] col = '0;
    logic [7:0]  din = '0;
    logic        vin = 1'b0;
    logic        fin = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  m8_data, m16_data, d8_data, ds_data;
    logic        m8_valid, m16_valid, d8_valid, ds_valid;
    logic        m8_fas, m16_fas, d8_fas, ds_fas;
    logic [7:0]  m8_crc, d8_crc, ds_crc;
    logic [15:0] m16_crc;
    logic        m8_err, m16_err, d8_err, ds_err;
    logic [15:0] m8_cnt, m16_cnt, d8_cnt;
    logic [1:0]  ds_cnt;
    logic        m8_done, m16_done, d8_done, ds_done;

    crc_frame_engine #(.MAP_MODE(1), .CRC_W(8), .POLY(8'h07)) u_map8 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(vin), .i_frame_data_fas(fin), .o_frame_data(m8_data),
        .o_frame_data_valid(m8_valid), .o_frame_data_fas(m8_fas), .o_crc_val(m8_crc),
        .o_crc_err(m8_err), .o_crc_err_cnt(m8_cnt), .o_frame_done(m8_done));

    crc_frame_engine #(.MAP_MODE(1), .CRC_W(16), .POLY(16'h1021)) u_map16 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(vin), .i_frame_data_fas(fin), .o_frame_data(m16_data),
        .o_frame_data_valid(m16_valid), .o_frame_data_fas(m16_fas), .o_crc_val(m16_crc),
        .o_crc_err(m16_err), .o_crc_err_cnt(m16_cnt), .o_frame_done(m16_done));

    crc_frame_engine #(.MAP_MODE(0), .CRC_W(8), .POLY(8'h07)) u_dem8 (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(vin), .i_frame_data_fas(fin), .o_frame_data(d8_data),
        .o_frame_data_valid(d8_valid), .o_frame_data_fas(d8_fas), .o_crc_val(d8_crc),
        .o_crc_err(d8_err), .o_crc_err_cnt(d8_cnt), .o_frame_done(d8_done));

    crc_frame_engine #(.MAP_MODE(0), .CRC_W(8), .POLY(8'h07), .ERR_CNT_W(2)) u_dem8s (
        .i_clk(clk), .i_rst(rst), .i_row_cnt(row), .i_col_cnt(col), .i_frame_data(din),
        .i_frame_data_valid(vin), .i_frame_data_fas(fin), .o_frame_data(ds_data),
        .o_frame_data_valid(ds_valid), .o_frame_data_fas(ds_fas), .o_crc_val(ds_crc),
        .o_crc_err(ds_err), .o_crc_err_cnt(ds_cnt), .o_frame_done(ds_done));

    typedef struct {
        logic [7:0] din;
        logic [7:0] e8;
        logic [7:0] e16;
        logic       v;
        logic       f;
        logic       dn8;
        logic       dn16;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pay [0:4*NPAY-1];
    logic [7:0]  last_r8;
    logic [15:0] last_r16;
    int          exp_cnt8 = 0;
    int          exp_cnts = 0;

    // Reference CRCs in byte-at-a-time long-division form.
    function automatic logic [7:0] ref8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] ref16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Scoreboard: each driven cycle is compared one clock later.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++; if (m8_data !== cur.e8) begin errors++; $display("FAIL map8_data: got %02h exp %02h", m8_data, cur.e8); end
            checks++; if (m16_data !== cur.e16) begin errors++; $display("FAIL map16_data: got %02h exp %02h", m16_data, cur.e16); end
            checks++; if (d8_data !== cur.din || ds_data !== cur.din) begin errors++; $display("FAIL demap_data: got %02h/%02h exp %02h", d8_data, ds_data, cur.din); end
            checks++; if ({m8_valid, m16_valid, d8_valid, ds_valid} !== {4{cur.v}}) begin errors++; $display("FAIL valid_delay: got %b exp %b", {m8_valid, m16_valid, d8_valid, ds_valid}, {4{cur.v}}); end
            checks++; if ({m8_fas, m16_fas, d8_fas, ds_fas} !== {4{cur.f}}) begin errors++; $display("FAIL fas_delay: got %b exp %b", {m8_fas, m16_fas, d8_fas, ds_fas}, {4{cur.f}}); end
            checks++; if ({m8_done, d8_done, ds_done} !== {3{cur.dn8}}) begin errors++; $display("FAIL done8: got %b exp %b", {m8_done, d8_done, ds_done}, {3{cur.dn8}}); end
            checks++; if (m16_done !== cur.dn16) begin errors++; $display("FAIL done16: got %b exp %b", m16_done, cur.dn16); end
            checks++; if ({m8_err, m16_err, m8_cnt, m16_cnt} !== 34'd0) begin errors++; $display("FAIL map_err_zero: got %b %b %0d %0d exp 0", m8_err, m16_err, m8_cnt, m16_cnt); end
        end
    end

    task automatic cyc(input logic [1:0] r, input logic [10:0] c, input logic [7:0] d, input logic v,
                       input logic f, input logic [7:0] e8, input logic [7:0] e16, input logic dn8,
                       input logic dn16);
        exp_t e;
        @(negedge clk);
        row = r; col = c; din = d; vin = v; fin = f;
        e.din = d; e.e8 = e8; e.e16 = e16; e.v = v; e.f = f; e.dn8 = dn8; e.dn16 = dn16;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        vin = 1'b0; fin = 1'b0; din = 8'h00; row = 2'd0; col = 11'd0;
    endtask

    // pat 0: all-zero payload with 0x01 at row 3 col 1039; pat 1: bytes from pay[].
    // n_rows < 4 stops before the CRC slot (partial frame).
    task automatic send_frame(input int pat, input bit corrupt, input int gap_pct, input int n_rows);
        logic [7:0]  r8, d, s0;
        logic [15:0] r16;
        logic [10:0] c;
        logic        gf;
        r8 = 8'h00; r16 = 16'h0000;
        cyc(2'd0, 11'd0, 8'hF6, 1'b1, 1'b1, 8'hF6, 8'hF6, 1'b0, 1'b0);
        for (int r = 0; r < n_rows; r++) begin
            cyc(2'(r), 11'd5, 8'h28, 1'b1, 1'b0, 8'h28, 8'h28, 1'b0, 1'b0);
            for (int j = 0; j < NPAY; j++) begin
                c = (j == NPAY - 1) ? 11'd1039 : 11'(16 + j);
                if (pat == 0) d = (r == 3 && j == NPAY - 1) ? 8'h01 : 8'h00;
                else          d = pay[r * NPAY + j];
                if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                    gf = 1'($urandom_range(1));
                    cyc(2'(r), c, 8'hC3, 1'b0, gf, 8'hC3, 8'hC3, 1'b0, 1'b0);
                end
                cyc(2'(r), c, d, 1'b1, 1'b0, d, d, 1'b0, 1'b0);
                r8 = ref8(r8, d);
                r16 = ref16(r16, d);
            end
        end
        if (n_rows == 4) begin
            s0 = corrupt ? (r8 ^ 8'h01) : r8;
            cyc(2'd3, 11'd1040, s0, 1'b1, 1'b0, r8, r16[15:8], 1'b1, 1'b0);
            cyc(2'd3, 11'd1041, 8'hA5, 1'b1, 1'b0, 8'hA5, r16[7:0], 1'b0, 1'b1);
        end
        last_r8 = r8;
        last_r16 = r16;
    endtask

    task automatic fill_pay();
        for (int i = 0; i < 4 * NPAY; i++) pay[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; vin = 1'b1; fin = 1'b1; din = 8'hFF; row = 2'd3; col = 11'd1040;
        repeat (2) @(negedge clk);
        checks++; if ({m8_data, m8_valid, m8_fas, m8_done} !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %02h %b %b %b exp 0", m8_data, m8_valid, m8_fas, m8_done); end
        checks++; if (m8_crc !== 8'h00 || m16_crc !== 16'h0000) begin errors++; $display("FAIL reset_crc_val: got %02h %04h exp 00 0000", m8_crc, m16_crc); end
        checks++; if ({d8_err, d8_cnt, ds_err, ds_cnt} !== 20'd0) begin errors++; $display("FAIL reset_err: got %b %0d %b %0d exp 0", d8_err, d8_cnt, ds_err, ds_cnt); end
        checks++; if ({d8_data, d8_valid, d8_done, m16_done} !== 11'd0) begin errors++; $display("FAIL reset_demap_out: got %02h %b %b %b exp 0", d8_data, d8_valid, d8_done, m16_done); end
        rst = 1'b0; vin = 1'b0; fin = 1'b0; din = 8'h00;
    endtask

    task automatic test_map_vector();
        send_frame(0, 1'b0, 0, 4);
        idle();
        checks++; if (m8_crc !== 8'h07) begin errors++; $display("FAIL vec_crc8: got %02h exp 07", m8_crc); end
        checks++; if (m16_crc !== 16'h1021) begin errors++; $display("FAIL vec_crc16: got %04h exp 1021", m16_crc); end
        checks++; if (d8_err !== 1'b0 || d8_cnt !== 16'd0) begin errors++; $display("FAIL vec_demap_ok: got err %b cnt %0d exp 0 0", d8_err, d8_cnt); end
    endtask

    task automatic test_demap_error();
        send_frame(0, 1'b1, 0, 4);
        idle();
        exp_cnt8++; exp_cnts++;
        checks++; if (d8_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b exp 1", d8_err); end
        checks++; if (d8_cnt !== 16'(exp_cnt8) || ds_cnt !== 2'(exp_cnts)) begin errors++; $display("FAIL err_cnt: got %0d/%0d exp %0d/%0d", d8_cnt, ds_cnt, exp_cnt8, exp_cnts); end
        send_frame(0, 1'b0, 0, 0);
        idle();
        checks++; if (d8_err !== 1'b0 || ds_err !== 1'b0) begin errors++; $display("FAIL err_clear_on_fas: got %b %b exp 0", d8_err, ds_err); end
        checks++; if (d8_cnt !== 16'(exp_cnt8)) begin errors++; $display("FAIL err_cnt_hold: got %0d exp %0d", d8_cnt, exp_cnt8); end
    endtask

    task automatic test_gaps();
        fill_pay();
        send_frame(1, 1'b0, 0, 4);
        idle();
        checks++; if (m8_crc !== last_r8 || m16_crc !== last_r16) begin errors++; $display("FAIL gapfree_crc: got %02h %04h exp %02h %04h", m8_crc, m16_crc, last_r8, last_r16); end
        send_frame(1, 1'b0, 50, 4);
        idle();
        checks++; if (m8_crc !== last_r8 || m16_crc !== last_r16 || ds_crc !== last_r8) begin errors++; $display("FAIL gapped_crc: got %02h %04h %02h exp %02h %04h", m8_crc, m16_crc, ds_crc, last_r8, last_r16); end
        checks++; if (d8_err !== 1'b0 || d8_cnt !== 16'(exp_cnt8)) begin errors++; $display("FAIL gapped_demap: got %b %0d exp 0 %0d", d8_err, d8_cnt, exp_cnt8); end
    endtask

    task automatic test_abort_reset();
        fill_pay();
        send_frame(1, 1'b0, 0, 2);
        send_frame(1, 1'b0, 0, 4);
        idle();
        checks++; if (d8_err !== 1'b0 || d8_cnt !== 16'(exp_cnt8)) begin errors++; $display("FAIL abort_no_err: got %b %0d exp 0 %0d", d8_err, d8_cnt, exp_cnt8); end
        send_frame(1, 1'b0, 0, 3);
        @(negedge clk);
        rst = 1'b1; vin = 1'b1; din = 8'h77;
        @(negedge clk);
        exp_cnt8 = 0; exp_cnts = 0;
        checks++; if ({m8_data, m8_valid, m8_fas, m8_done, d8_err, d8_cnt, ds_cnt} !== 30'd0) begin errors++; $display("FAIL midframe_reset_out: got %02h %b %b %b %b %0d %0d exp 0", m8_data, m8_valid, m8_fas, m8_done, d8_err, d8_cnt, ds_cnt); end
        checks++; if (m8_crc !== 8'h00 || m16_crc !== 16'h0000 || d8_crc !== 8'h00) begin errors++; $display("FAIL midframe_reset_crc: got %02h %04h %02h exp init", m8_crc, m16_crc, d8_crc); end
        rst = 1'b0; vin = 1'b0;
        cyc(2'd3, 11'd1040, 8'h5A, 1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0);
        cyc(2'd1, 11'd20, 8'h33, 1'b1, 1'b0, 8'h33, 8'h33, 1'b0, 1'b0);
        idle();
        checks++; if (m8_crc !== 8'h00 || m16_crc !== 16'h0000) begin errors++; $display("FAIL wait_fas_no_update: got %02h %04h exp 00 0000", m8_crc, m16_crc); end
        send_frame(1, 1'b0, 0, 4);
        idle();
        checks++; if (m8_crc !== last_r8 || d8_err !== 1'b0 || d8_cnt !== 16'd0) begin errors++; $display("FAIL restart_after_reset: got %02h %b %0d exp %02h 0 0", m8_crc, d8_err, d8_cnt, last_r8); end
    endtask

    task automatic test_err_saturate();
        int seq [4];
        seq = '{1, 2, 3, 3};
        for (int i = 0; i < 4; i++) begin
            fill_pay();
            send_frame(1, 1'b1, 0, 4);
            idle();
            exp_cnt8++;
            exp_cnts = seq[i];
            checks++; if (ds_cnt !== 2'(seq[i]) || ds_err !== 1'b1) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d err %b exp %0d 1", i, ds_cnt, ds_err, seq[i]); end
            checks++; if (d8_cnt !== 16'(exp_cnt8)) begin errors++; $display("FAIL wide_cnt[%0d]: got %0d exp %0d", i, d8_cnt, exp_cnt8); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            fill_pay();
            send_frame(1, (i == 1), 0, 4);
            if (i == 1) begin
                exp_cnt8++;
                if (exp_cnts < 3) exp_cnts++;
            end
            checks++; if (d8_err !== (i == 1) || d8_cnt !== 16'(exp_cnt8)) begin errors++; $display("FAIL b2b[%0d]: got err %b cnt %0d exp %b %0d", i, d8_err, d8_cnt, (i == 1), exp_cnt8); end
        end
        idle();
        checks++; if (ds_cnt !== 2'(exp_cnts) || m16_crc !== last_r16) begin errors++; $display("FAIL b2b_final: got %0d %04h exp %0d %04h", ds_cnt, m16_crc, exp_cnts, last_r16); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_map_vector();
        test_demap_error();
        test_gaps();
        test_abort_reset();
        test_err_saturate();
        test_back_to_back();
        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
